// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS signed 64-bit products into a guarded accumulator.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp the result and flag overflow.
module product_accumulator #(
  parameter int N_TERMS = 8,
  parameter int GUARD_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        overflow,
  output logic [8:0]  count,
  output logic        busy
);
  localparam int AW = 64 + GUARD_W;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] acc, sum;
  logic [63:0] res_nx;
  logic accept, last;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  assign last = count == 9'(N_TERMS - 1);
  assign sum = acc + {{GUARD_W{product[63]}}, product};
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  logic ovf, ovf_q;
  // the sum fits in 64 bits only when the guard bits all match bit 63
  assign ovf = |sum[AW-1:63] && !(&sum[AW-1:63]);
  assign res_nx = !ovf ? sum[63:0] : sum[AW-1] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
  assign overflow = ovf_q;
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (accept && last) ovf_q <= ovf;
`else
  assign res_nx = sum[63:0];
  assign overflow = 1'b0;
`endif
  always_comb begin
    state_nx = state == IDLE  ? (start ? ACCUM : IDLE) :
               state == ACCUM ? (accept && last ? DONE : ACCUM) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        acc <= '0;
        count <= '0;
      end else if (accept) begin
        acc <= sum;
        count <= count + 9'd1;
        if (last) result <= res_nx;
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and randomized runs against an arithmetic reference model.
module tb_product_accumulator;
  localparam int N = 4;
  localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINV = -MAXV - 128'sd1;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [63:0] product, result;
  logic [8:0] count;
  logic [63:0] pv [N];
  int errors = 0;
  int checks = 0;

  product_accumulator #(.N_TERMS(N), .GUARD_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model(output logic [63:0] res, output logic ovf);
    logic signed [127:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + {{64{pv[i][63]}}, pv[i]};
    res = s[63:0];
    ovf = 1'b0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    if (s > MAXV) begin res = 64'h7FFF_FFFF_FFFF_FFFF; ovf = 1'b1; end
    if (s < MINV) begin res = 64'h8000_0000_0000_0000; ovf = 1'b1; end
`endif
  endtask

  task automatic run(input int gap, input int hold, input bit rnd);
    logic [63:0] er;
    logic eo;
    int g;
    model(er, eo);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(in_ready), 64'd1);
    check("run_count0", 64'(count), 64'd0);
    for (int i = 0; i < N; i++) begin
      g = rnd ? $urandom_range(0, 3) : gap;
      repeat (g) begin
        in_valid = 1'b0;
        product = {$urandom, $urandom};
        start = $urandom_range(0, 1);
        tick();
        start = 1'b0;
        check("gap_count", 64'(count), 64'(i));
        check("gap_in_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b1;
      product = pv[i];
      tick();
      in_valid = 1'b0;
      if (i < N - 1) check("acc_count", 64'(count), 64'(i + 1));
    end
    check("done_valid", 64'(out_valid), 64'd1);
    check("done_in_ready", 64'(in_ready), 64'd0);
    check("done_result", result, er);
    check("done_overflow", 64'(overflow), 64'(eo));
    check("done_count", 64'(count), 64'(N));
    g = rnd ? $urandom_range(0, 4) : hold;
    repeat (g) begin
      out_ready = 1'b0;
      start = $urandom_range(0, 1);
      tick();
      start = 1'b0;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", result, er);
      check("hold_count", 64'(count), 64'(N));
    end
    out_ready = 1'b1;
    start = $urandom_range(0, 1);
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("ack_valid", 64'(out_valid), 64'd0);
    check("ack_busy", 64'(busy), 64'd0);
    tick();
    check("idle_stays", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; product = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    tick();
    check("idle_no_start", 64'(busy), 64'd0);
    pv = '{64'd10, -64'sd3, 64'd7, 64'd100};
    run(0, 0, 1'b0);
    run(3, 5, 1'b0);
    pv = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
    run(0, 1, 1'b0);
    pv = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
    run(1, 0, 1'b0);
    pv = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd5, -64'sd6};
    run(0, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    product = 64'd50;
    tick();
    tick();
    in_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    pv = '{64'd1, 64'd1, 64'd1, 64'd1};
    run(0, 0, 1'b0);
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++)
        case ($urandom_range(0, 4))
          0: pv[i] = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
          1: pv[i] = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
          2: pv[i] = 64'($signed($urandom_range(0, 2000)) - 1000);
          default: pv[i] = {$urandom, $urandom};
        endcase
      run(0, 0, 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N_TERMS, default 8, number of products summed per run (legal 1..256).
REQ-002 Parameter GUARD_W, default 8, guard bits above 64 in the internal accumulator (legal 1..16).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a run; sampled only in IDLE.
REQ-006 in_valid  input  1  product is valid this cycle.
REQ-007 in_ready  output  1  block accepts a product this cycle.
REQ-008 product  input  64  signed 64-bit product from the 32x32 Booth multiplier.
REQ-009 out_valid  output  1  result valid, held until accepted.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  64  signed accumulated sum.
REQ-012 overflow  output  1  sum left the signed 64-bit range; valid with out_valid.
REQ-013 count  output  9  products accepted in the current run.
REQ-014 busy  output  1  high in ACCUM or DONE.

Function
REQ-015 FSM states IDLE, ACCUM, DONE; encoding free.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> acc=0, count=0, next state ACCUM.
REQ-017 ACCUM: in_ready=1; accept = in_valid & in_ready; on accept acc <= acc + sign-extended product (64+GUARD_W bits), count <= count+1.
REQ-018 ACCUM: accept with count==N_TERMS-1 -> next state DONE; result and overflow registered in the same edge.
REQ-019 Latency: out_valid rises the cycle after the final accepted product; one product per cycle maximum throughput.
REQ-020 Cycles without in_valid in ACCUM leave acc and count unchanged.
REQ-021 DONE: out_valid=1, in_ready=0; result, overflow, count stable until out_valid & out_ready, then IDLE.
REQ-022 start outside IDLE is ignored; start and rst together -> rst wins.
REQ-023 Same-cycle handshake out_valid & out_ready with start: start ignored (state is DONE that cycle).
REQ-024 overflow=1 iff acc < -2^63 or acc > 2^63-1 at completion; guard bits make intermediate sums exact for N_TERMS<=2^GUARD_W.
REQ-025 out_valid shall not depend combinationally on out_ready; in_ready shall not depend combinationally on in_valid.

Reset
REQ-026 rst=1 at a rising edge: state IDLE, acc=0, count=0, result=0, overflow=0, out_valid=0, in_ready=0, busy=0.
REQ-027 Reset mid-run discards partial sum; the next run starts from 0.

Configuration
REQ-028 Macro PRODUCT_ACCUMULATOR_SATURATE_EN defined: on overflow, result clamps to 0x7FFF_FFFF_FFFF_FFFF (positive) or 0x8000_0000_0000_0000 (negative); overflow=1.
REQ-029 Macro undefined: result = acc[63:0] (two's-complement wrap); overflow port driven 0; no clamp logic present.

Verification
REQ-030 N_TERMS=4, start, products 10, -3, 7, 100 back-to-back -> out_valid 1 cycle after 4th accept, result=114, count=4, overflow=0.
REQ-031 in_valid gaps of 3 cycles between products; out_ready low 5 cycles in DONE -> acc unchanged during gaps; result, out_valid held stable; in_ready=0 in DONE.
REQ-032 N_TERMS=2, products 0x7FFF_FFFF_FFFF_FFFF twice -> SAT_EN: result 0x7FFF_FFFF_FFFF_FFFF, overflow=1; without: result 0xFFFF_FFFF_FFFF_FFFE, overflow=0.
REQ-033 N_TERMS=2, products 0x8000_0000_0000_0000 twice -> SAT_EN: result 0x8000_0000_0000_0000, overflow=1; without: result 0, overflow=0.
REQ-034 N_TERMS=4, rst after 2 accepts -> next cycle IDLE, all outputs 0; new run of 1,1,1,1 -> result=4.
REQ-035 start pulsed during ACCUM and DONE -> no change to acc, count or state.
